// File: rtl/axi_pkg.sv
// Shared AXI3 constants and FSM state encodings for the RAM responder and the master side.
package axi_pkg;

   localparam int AXI_ID_W       = 4;
   localparam int AXI_LEN_W      = 4;
   localparam int AXI_DATA_W     = 32;
   localparam int AXI_BEAT_BYTES = 4;
   localparam int AXI_BEAT_SHIFT = 2;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] BURST_INCR = 2'b01;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

endpackage

// File: rtl/axi_ram_array.sv
// Word-organised RAM: one byte-enabled write port, one synchronous read port.
// Contents are not reset; only the read-data register is.
module axi_ram_array
   import axi_pkg::*;
#(
   parameter int ADDR_W = 12
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      we,
   input  logic [ADDR_W-1:0]         waddr,
   input  logic [AXI_DATA_W-1:0]     wdata,
   input  logic [AXI_BEAT_BYTES-1:0] wbe,
   input  logic                      re,
   input  logic [ADDR_W-1:0]         raddr,
   output logic [AXI_DATA_W-1:0]     rdata
);

   logic [AXI_DATA_W-1:0] mem [2**ADDR_W];
   logic [AXI_DATA_W-1:0] rdata_d;
   logic [AXI_DATA_W-1:0] rdata_q;

   // Byte-lane writes; a read of the same word on the same edge sees the old data.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < AXI_BEAT_BYTES; i++) begin
            if (wbe[i]) begin
               mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
   end

   // Read register only updates on a load request so the beat stays stable otherwise.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem[raddr];
      end
   end

   // Read-data register with reset so rdata is 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 responder backed by on-chip RAM; one outstanding read and one write burst.
//
// state  | meaning
// R_IDLE | arready high, waiting for a read address
// R_DATA | presenting read beats, advancing on rready
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, committing beats until wlast
// W_RESP | bvalid high, waiting for bready
module axi_ram_slave
   import axi_pkg::*;
#(
   parameter int ADDR_W = 12
)
(
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [AXI_ID_W-1:0]   arid,
   input  logic [31:0]           araddr,
   input  logic [AXI_LEN_W-1:0]  arlen,
   input  logic [2:0]            arsize,
   input  logic [1:0]            arburst,
   input  logic [1:0]            arlock,
   input  logic [3:0]            arcache,
   input  logic [2:0]            arprot,
   input  logic                  arvalid,
   output logic                  arready,
   output logic [AXI_ID_W-1:0]   rid,
   output logic [AXI_DATA_W-1:0] rdata,
   output logic [1:0]            rresp,
   output logic                  rlast,
   output logic                  rvalid,
   input  logic                  rready,
   input  logic [AXI_ID_W-1:0]   awid,
   input  logic [31:0]           awaddr,
   input  logic [AXI_LEN_W-1:0]  awlen,
   input  logic [2:0]            awsize,
   input  logic [1:0]            awburst,
   input  logic [1:0]            awlock,
   input  logic [3:0]            awcache,
   input  logic [2:0]            awprot,
   input  logic                  awvalid,
   output logic                  awready,
   input  logic [AXI_ID_W-1:0]   wid,
   input  logic [AXI_DATA_W-1:0] wdata,
   input  logic [3:0]            wstrb,
   input  logic                  wlast,
   input  logic                  wvalid,
   output logic                  wready,
   output logic [AXI_ID_W-1:0]   bid,
   output logic [1:0]            bresp,
   output logic                  bvalid,
   input  logic                  bready
);

   rd_state_e             r_state_d, r_state_q;
   logic                  arready_d, arready_q;
   logic                  rvalid_d, rvalid_q;
   logic                  rlast_d, rlast_q;
   logic [AXI_ID_W-1:0]   rid_d, rid_q;
   logic [ADDR_W-1:0]     rptr_d, rptr_q;
   logic [AXI_LEN_W-1:0]  rcnt_d, rcnt_q;
   logic [AXI_LEN_W-1:0]  rlen_d, rlen_q;

   wr_state_e             w_state_d, w_state_q;
   logic                  awready_d, awready_q;
   logic                  wready_d, wready_q;
   logic                  bvalid_d, bvalid_q;
   logic [AXI_ID_W-1:0]   bid_d, bid_q;
   logic [ADDR_W-1:0]     wptr_d, wptr_q;

   logic                  ram_re;
   logic [ADDR_W-1:0]     ram_raddr;
   logic                  ram_we;
   logic [ADDR_W-1:0]     ar_index;
   logic [ADDR_W-1:0]     aw_index;

   // Beats are always 4 bytes; address bits outside the word index are dropped.
   assign ar_index = araddr[ADDR_W+AXI_BEAT_SHIFT-1:AXI_BEAT_SHIFT];
   assign aw_index = awaddr[ADDR_W+AXI_BEAT_SHIFT-1:AXI_BEAT_SHIFT];

   logic unused_inputs;
   assign unused_inputs = ^{arsize, arburst == BURST_INCR, arlock, arcache, arprot,
                            awsize, awburst == BURST_INCR, awlock, awcache, awprot,
                            awlen, wid,
                            araddr[31:ADDR_W+AXI_BEAT_SHIFT], araddr[AXI_BEAT_SHIFT-1:0],
                            awaddr[31:ADDR_W+AXI_BEAT_SHIFT], awaddr[AXI_BEAT_SHIFT-1:0]};

   axi_ram_array #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (aclk),
      .rst_n (aresetn),
      .we    (ram_we),
      .waddr (wptr_q),
      .wdata (wdata),
      .wbe   (wstrb),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (rdata)
   );

   // Read FSM: accept AR, load the next word from RAM on each completed beat.
   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rid_d     = rid_q;
      rptr_d    = rptr_q;
      rcnt_d    = rcnt_q;
      rlen_d    = rlen_q;
      ram_re    = 1'b0;
      ram_raddr = rptr_q;
      case (r_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (arvalid && arready_q) begin
               rid_d     = arid;
               rptr_d    = ar_index;
               rcnt_d    = '0;
               rlen_d    = arlen;
               ram_re    = 1'b1;
               ram_raddr = ar_index;
               rvalid_d  = 1'b1;
               rlast_d   = (arlen == '0);
               arready_d = 1'b0;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (rvalid_q && rready) begin
               if (!rlast_q) begin
                  rptr_d    = rptr_q + ADDR_W'(1);
                  rcnt_d    = rcnt_q + AXI_LEN_W'(1);
                  ram_re    = 1'b1;
                  ram_raddr = rptr_q + ADDR_W'(1);
                  rlast_d   = ((rcnt_q + AXI_LEN_W'(1)) == rlen_q);
               end else begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
                  r_state_d = R_IDLE;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Read FSM registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rptr_q    <= '0;
         rcnt_q    <= '0;
         rlen_q    <= '0;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rid_q     <= rid_d;
         rptr_q    <= rptr_d;
         rcnt_q    <= rcnt_d;
         rlen_q    <= rlen_d;
      end
   end

   // Write FSM: accept AW, commit beats until wlast (awlen is not enforced), then respond.
   always_comb begin
      w_state_d = w_state_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bid_d     = bid_q;
      wptr_d    = wptr_q;
      ram_we    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            awready_d = 1'b1;
            wready_d  = 1'b0;
            if (awvalid && awready_q) begin
               bid_d     = awid;
               wptr_d    = aw_index;
               awready_d = 1'b0;
               wready_d  = 1'b1;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (wvalid && wready_q) begin
               ram_we = 1'b1;
               wptr_d = wptr_q + ADDR_W'(1);
               if (wlast) begin
                  wready_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (bvalid_q && bready) begin
               bvalid_d  = 1'b0;
               awready_d = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Write FSM registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         wptr_q    <= '0;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         wptr_q    <= wptr_d;
      end
   end

   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rlast   = rlast_q;
   assign rid     = rid_q;
   assign rresp   = RESP_OKAY;
   assign awready = awready_q;
   assign wready  = wready_q;
   assign bvalid  = bvalid_q;
   assign bid     = bid_q;
   assign bresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Randomised bench for axi_ram_slave against a word-array memory model.
module tb_axi_ram_slave;

   localparam int ADDR_W = 12;
   localparam int DEPTH  = 4096;

   logic        aclk, aresetn;
   logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
   logic [31:0] araddr, awaddr, wdata;
   logic [2:0]  arsize, arprot, awsize, awprot;
   logic [1:0]  arburst, arlock, awburst, awlock;
   logic        arvalid, rready, awvalid, wlast, wvalid, bready;
   logic        arready, rlast, rvalid, awready, wready, bvalid;
   logic [3:0]  rid, bid;
   logic [31:0] rdata;
   logic [1:0]  rresp, bresp;

   axi_ram_slave #(.ADDR_W(ADDR_W)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
   endtask

   logic [31:0] model [DEPTH];
   logic [31:0] wb_data [16];
   logic [3:0]  wb_strb [16];
   logic [31:0] first_rd;

   function automatic int widx(input logic [31:0] addr);
      return int'((addr >> 2) % DEPTH);
   endfunction

   task automatic axi_write(input logic [3:0] id, input logic [31:0] addr,
                            input int nbeats, input int bdelay);
      int cyc;
      int w;
      w = widx(addr);
      awid = id; awaddr = addr; awlen = 4'(nbeats - 1); awvalid = 1'b1;
      cyc = 0;
      while (!awready && cyc < 100) begin @(negedge aclk); cyc++; end
      chk("aw_accept", 32'(awready), 32'd1);
      @(negedge aclk);
      awvalid = 1'b0;
      chk("awready_drop", 32'(awready), 32'd0);
      chk("wready_rise", 32'(wready), 32'd1);
      for (int b = 0; b < nbeats; b++) begin
         wdata = wb_data[b]; wstrb = wb_strb[b]; wlast = (b == nbeats - 1); wvalid = 1'b1;
         cyc = 0;
         while (!wready && cyc < 100) begin @(negedge aclk); cyc++; end
         chk("w_accept", 32'(wready), 32'd1);
         for (int i = 0; i < 4; i++)
            if (wb_strb[b][i]) model[(w + b) % DEPTH][i*8 +: 8] = wb_data[b][i*8 +: 8];
         @(negedge aclk);
      end
      wvalid = 1'b0; wlast = 1'b0;
      chk("bvalid_rise", 32'(bvalid), 32'd1);
      for (int k = 0; k < bdelay; k++) begin
         chk("bvalid_hold", 32'(bvalid), 32'd1);
         chk("awready_hold", 32'(awready), 32'd0);
         @(negedge aclk);
      end
      bready = 1'b1;
      chk("bid", 32'(bid), 32'(id));
      chk("bresp", 32'(bresp), 32'd0);
      @(negedge aclk);
      bready = 1'b0;
      chk("bvalid_drop", 32'(bvalid), 32'd0);
      chk("awready_back", 32'(awready), 32'd1);
   endtask

   // mode: 0 rready always high, 1 toggling, 2 random. abort_at >= 0 returns once that beat is shown.
   task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int mode, input int abort_at);
      int cyc;
      int beat;
      int w;
      logic rr;
      w = widx(addr);
      arid = id; araddr = addr; arlen = 4'(len); arvalid = 1'b1;
      cyc = 0;
      while (!arready && cyc < 100) begin @(negedge aclk); cyc++; end
      chk("ar_accept", 32'(arready), 32'd1);
      @(negedge aclk);
      arvalid = 1'b0;
      chk("arready_drop", 32'(arready), 32'd0);
      chk("rvalid_first", 32'(rvalid), 32'd1);
      beat = 0; cyc = 0;
      while (beat <= len && cyc < 400) begin
         if (abort_at == beat && rvalid) return;
         case (mode)
            0:       rr = 1'b1;
            1:       rr = (cyc % 2 == 0);
            default: rr = 1'($urandom_range(0, 1));
         endcase
         rready = rr;
         if (rvalid) begin
            if (beat == 0) first_rd = rdata;
            chk("rdata", rdata, model[(w + beat) % DEPTH]);
            chk("rlast", 32'(rlast), 32'(beat == len));
            chk("rid", 32'(rid), 32'(id));
            chk("rresp", 32'(rresp), 32'd0);
            if (rr) beat++;
         end
         @(negedge aclk);
         cyc++;
      end
      rready = 1'b0;
      chk("r_done", 32'(beat), 32'(len + 1));
      chk("rvalid_drop", 32'(rvalid), 32'd0);
      chk("arready_back", 32'(arready), 32'd1);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
      #1;
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rlast", 32'(rlast), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_rid", 32'(rid), 32'd0);
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_wready", 32'(wready), 32'd0);
      chk("rst_bvalid", 32'(bvalid), 32'd0);
      chk("rst_bid", 32'(bid), 32'd0);
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      chk("arready_pre_edge", 32'(arready), 32'd0);
      @(negedge aclk);
      chk("arready_rise", 32'(arready), 32'd1);
      chk("awready_rise", 32'(awready), 32'd1);
      chk("wready_idle", 32'(wready), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_pass %0d n_total %0d", n_pass, n_total);
      $fatal(1);
   end

   initial begin
      arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arlock = '0;
      arcache = '0; arprot = '0; awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2;
      awburst = 2'b01; awlock = '0; awcache = '0; awprot = '0; wid = '0; wdata = '0;
      wstrb = '0; first_rd = '0;
      aresetn = 1'b1;
      @(negedge aclk);
      do_reset();

      // Fill the whole RAM so every later read has a defined expectation.
      for (int blk = 0; blk < DEPTH / 16; blk++) begin
         for (int b = 0; b < 16; b++) begin wb_data[b] = $urandom; wb_strb[b] = 4'hF; end
         axi_write(4'(blk), 32'(blk * 64), 16, 0);
      end

      // Single beat write/read.
      wb_data[0] = 32'hDEADBEEF; wb_strb[0] = 4'hF;
      axi_write(4'h5, 32'h100, 1, 0);
      axi_read(4'h9, 32'h100, 0, 0, -1);
      chk("single_rd", first_rd, 32'hDEADBEEF);

      // Byte-strobe merge.
      wb_data[0] = 32'h11223344; wb_strb[0] = 4'hF;
      axi_write(4'h1, 32'h104, 1, 0);
      wb_data[0] = 32'h0000AA00; wb_strb[0] = 4'b0010;
      axi_write(4'h2, 32'h104, 1, 0);
      axi_read(4'h3, 32'h104, 0, 0, -1);
      chk("strb_rd", first_rd, 32'h1122AA44);

      // 16-beat burst over index-valued words.
      for (int b = 0; b < 16; b++) begin wb_data[b] = 32'(16 + b); wb_strb[b] = 4'hF; end
      axi_write(4'h7, 32'h40, 16, 0);
      axi_read(4'h0, 32'h40, 15, 0, -1);
      chk("burst16_first", first_rd, 32'h10);

      // rready toggling.
      axi_read(4'h6, 32'h40, 7, 1, -1);

      // Concurrent read and write with a held write response.
      for (int b = 0; b < 4; b++) begin wb_data[b] = $urandom; wb_strb[b] = 4'hF; end
      fork
         axi_read(4'h1, 32'h200, 7, 0, -1);
         axi_write(4'h2, 32'h300, 4, 5);
      join

      // Wrap past the top of the RAM with high address bits set.
      axi_read(4'h3, 32'hFFFF_3FF8, 5, 2, -1);

      // Reset during beat 3 of an 8-beat read.
      axi_read(4'h4, 32'h80, 7, 0, 2);
      rready = 1'b0;
      do_reset();
      axi_read(4'h4, 32'h600, 0, 0, -1);
      axi_read(4'h4, 32'h80, 7, 2, -1);

      // Random traffic.
      for (int it = 0; it < 30; it++) begin
         int nb;
         nb = $urandom_range(1, 16);
         for (int b = 0; b < 16; b++) begin
            wb_data[b] = $urandom;
            wb_strb[b] = 4'($urandom);
         end
         axi_write(4'($urandom), $urandom, nb, $urandom_range(0, 3));
         axi_read(4'($urandom), $urandom, $urandom_range(0, 15), $urandom_range(0, 2), -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
